// File: rtl/memory_reader.sv
// Sweeps addresses 0..LAST_ADDRESS over a four-phase request/acknowledge handshake,
// capturing each word into buffer. Define MEMORY_READER_CHECKSUM_EN to enable the running checksum.
module memory_reader #(
    parameter int ADDRESS_WIDTH = 10,
    parameter int DATA_WIDTH    = 16,
    parameter int LAST_ADDRESS  = 1023,
    parameter int TIMEOUT       = 255
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     step,
    output logic                     request,
    output logic [ADDRESS_WIDTH-1:0] address,
    input  logic                     acknowledge,
    input  logic [DATA_WIDTH-1:0]    read_data,
    output logic [DATA_WIDTH-1:0]    buffer,
    output logic                     valid,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [DATA_WIDTH-1:0]    checksum,
    output logic [2:0]               fsm_state
);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        REQUEST      = 3'd1,
        WAIT_RELEASE = 3'd2,
        PAUSE        = 3'd3,
        DONE         = 3'd4
    } state_t;

    localparam int TIMER_WIDTH = $clog2(TIMEOUT + 1);
    localparam logic [TIMER_WIDTH-1:0]   TIMER_LAST   = TIMER_WIDTH'(TIMEOUT - 1);
    localparam logic [TIMER_WIDTH-1:0]   TIMER_ONE    = TIMER_WIDTH'(1);
    localparam logic [ADDRESS_WIDTH-1:0] ADDRESS_LAST = ADDRESS_WIDTH'(LAST_ADDRESS);
    localparam logic [ADDRESS_WIDTH-1:0] ADDRESS_ONE  = ADDRESS_WIDTH'(1);

    state_t                 state;
    state_t                 state_next;
    logic [TIMER_WIDTH-1:0] timer;
    logic                   capture;
    logic                   expire;
    logic                   clear;
    logic                   advance;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // request is decoded from state so the asynchronous reset drops it at once.
    always_comb begin
        state_next = state;
        request    = 1'b0;
        capture    = 1'b0;
        expire     = 1'b0;
        clear      = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    clear      = 1'b1;
                    state_next = REQUEST;
                end
            end
            REQUEST: begin
                request = 1'b1;
                if (acknowledge) begin
                    capture    = 1'b1;
                    state_next = WAIT_RELEASE;
                end else if (timer == TIMER_LAST) begin
                    expire     = 1'b1;
                    state_next = DONE;
                end
            end
            WAIT_RELEASE: begin
                if (!acknowledge) begin
                    state_next = (address == ADDRESS_LAST) ? DONE : PAUSE;
                end
            end
            PAUSE: begin
                if (step) begin
                    advance    = 1'b1;
                    state_next = REQUEST;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy      = (state != IDLE) && (state != DONE);
    assign done      = (state == DONE);
    assign fsm_state = state;

    // timer rests at zero outside REQUEST, so every request starts a fresh count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            address <= '0;
            buffer  <= '0;
            valid   <= 1'b0;
            error   <= 1'b0;
            timer   <= '0;
        end else begin
            valid <= capture;
            timer <= (state == REQUEST) ? timer + TIMER_ONE : '0;
            if (clear) begin
                address <= '0;
            end else if (advance) begin
                address <= address + ADDRESS_ONE;
            end
            if (capture) begin
                buffer <= read_data;
            end
            if (clear) begin
                error <= 1'b0;
            end else if (expire) begin
                error <= 1'b1;
            end
        end
    end

`ifdef MEMORY_READER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (capture) begin
            sum <= sum + read_data;
        end
    end

    assign checksum = sum;
`else
    assign checksum = '0;
`endif

endmodule
